// File: rtl/rs_correct_apply.sv
// rs_correct_apply: applies a Reed-Solomon error pattern to a received
// codeword, LANES bytes per cycle, and flags blocks with more than T_MAX
// nonzero error bytes as uncorrectable. Those blocks are returned unmodified.
// Optional feature macro: RS_CORRECT_STATS_EN adds the stat_ok / stat_fail
// handoff counters.
module rs_correct_apply #(
  parameter int K_BYTES = 200,
  parameter int LANES   = 8,
  parameter int T_MAX   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [K_BYTES*8-1:0] rx_data,
  input  logic [K_BYTES*8-1:0] err_pat,
  input  logic                 has_err,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [K_BYTES*8-1:0] corr_data,
  output logic [7:0]           err_count,
  output logic                 uncorr
`ifdef RS_CORRECT_STATS_EN
  ,
  output logic [31:0]          stat_ok,
  output logic [31:0]          stat_fail
`endif
);

  localparam int NGROUPS = K_BYTES / LANES;
  localparam int CW      = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
  localparam logic [CW-1:0] LAST_GRP = CW'(NGROUPS - 1);
  localparam logic [7:0]    T_MAX_B  = 8'(T_MAX);

  if (K_BYTES % LANES != 0) begin : g_bad_lanes
    $error("rs_correct_apply: K_BYTES must be a multiple of LANES");
  end
  if (K_BYTES > 255) begin : g_bad_k
    $error("rs_correct_apply: K_BYTES above 255 overflows the 8-bit error count");
  end

  typedef enum logic [1:0] {IDLE, CORRECT, DONE} state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   in_ready_q, in_ready_d;
  logic                   out_valid_q, out_valid_d;
  logic [K_BYTES*8-1:0]   corr_data_q, corr_data_d;
  logic [7:0]             err_count_q, err_count_d;
  logic                   uncorr_q, uncorr_d;
  logic [K_BYTES*8-1:0]   rx_q, err_q;
  logic                   load;
  logic [7:0]             grp_nz;
  logic [7:0]             run_sum;
  int                     grp_base;
`ifdef RS_CORRECT_STATS_EN
  logic [31:0]            stat_ok_q, stat_ok_d, stat_fail_q, stat_fail_d;
`endif

  assign load = (state_q == IDLE) && in_valid && in_ready_q && !clr;

  // Count nonzero error bytes in the group selected by the lane counter.
  always_comb begin
    grp_nz   = '0;
    grp_base = int'(cnt_q) * LANES;
    for (int l = 0; l < LANES; l++) begin
      if (err_q[(grp_base + l)*8 +: 8] != 8'h00) grp_nz = grp_nz + 8'd1;
    end
  end

  // Next-state and next-output logic for the IDLE/CORRECT/DONE sequencer.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    corr_data_d = corr_data_q;
    err_count_d = err_count_q;
    uncorr_d    = uncorr_q;
    run_sum     = err_count_q + grp_nz;
`ifdef RS_CORRECT_STATS_EN
    stat_ok_d   = stat_ok_q;
    stat_fail_d = stat_fail_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (load) begin
          in_ready_d  = 1'b0;
          err_count_d = '0;
          uncorr_d    = 1'b0;
          cnt_d       = '0;
          if (has_err) begin
            state_d = CORRECT;
          end else begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            corr_data_d = rx_data;
          end
        end
      end
      CORRECT: begin
        // corr_data doubles as the work buffer; it is invisible until DONE.
        for (int l = 0; l < LANES; l++) begin
          corr_data_d[(grp_base + l)*8 +: 8] =
            rx_q[(grp_base + l)*8 +: 8] ^ err_q[(grp_base + l)*8 +: 8];
        end
        err_count_d = run_sum;
        cnt_d       = cnt_q + CW'(1);
        if (cnt_q == LAST_GRP) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          cnt_d       = '0;
          if (run_sum > T_MAX_B) begin
            uncorr_d    = 1'b1;
            corr_data_d = rx_q;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
`ifdef RS_CORRECT_STATS_EN
          if (uncorr_q) begin
            if (stat_fail_q != '1) stat_fail_d = stat_fail_q + 32'd1;
          end else begin
            if (stat_ok_q != '1) stat_ok_d = stat_ok_q + 32'd1;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    if (clr) begin
      state_d     = IDLE;
      cnt_d       = '0;
      in_ready_d  = 1'b1;
      out_valid_d = 1'b0;
      corr_data_d = '0;
      err_count_d = '0;
      uncorr_d    = 1'b0;
`ifdef RS_CORRECT_STATS_EN
      stat_ok_d   = '0;
      stat_fail_d = '0;
`endif
    end
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      corr_data_q <= '0;
      err_count_q <= '0;
      uncorr_q    <= 1'b0;
`ifdef RS_CORRECT_STATS_EN
      stat_ok_q   <= '0;
      stat_fail_q <= '0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      corr_data_q <= corr_data_d;
      err_count_q <= err_count_d;
      uncorr_q    <= uncorr_d;
`ifdef RS_CORRECT_STATS_EN
      stat_ok_q   <= stat_ok_d;
      stat_fail_q <= stat_fail_d;
`endif
    end
  end

  // Capture the accepted block; held untouched until the next acceptance.
  // NOTE: these wide data holding registers are not reset; they are always written before being read.
  always_ff @(posedge clk) begin
    if (load) begin
      rx_q  <= rx_data;
      err_q <= err_pat;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign corr_data = corr_data_q;
  assign err_count = err_count_q;
  assign uncorr    = uncorr_q;
`ifdef RS_CORRECT_STATS_EN
  assign stat_ok   = stat_ok_q;
  assign stat_fail = stat_fail_q;
`endif

endmodule
